mips_exec_decode: RTL and testbench

MIPS_EXEC_DECODE -- requirements
Module: mips_exec_decode

---
 rtl/mips_pkg.sv | 76 +++++++
 rtl/alu_core.sv | 34 +++
 rtl/mips_exec_decode.sv | 169 ++++++++++++++++
 tb/tb_mips_exec_decode.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared constants for the MIPS execute-stage decode: opcodes, funct codes,
// ALU operation classes, ALU control encodings and control-vector bit positions.
package mips_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  // Operation class handed from the main decoder to the ALU control decoder
  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_FUNCT = 3'b010;
  localparam logic [2:0] ALUOP_AND   = 3'b011;
  localparam logic [2:0] ALUOP_OR    = 3'b100;
  localparam logic [2:0] ALUOP_SLT   = 3'b101;
  localparam logic [2:0] ALUOP_SLTU  = 3'b110;
  localparam logic [2:0] ALUOP_LUI   = 3'b111;

  // ALU control encodings; codes not listed here produce a zero result
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_NOR  = 4'b0100;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b1001;
  localparam logic [3:0] ALU_SRL  = 4'b1010;
  localparam logic [3:0] ALU_SRA  = 4'b1011;
  localparam logic [3:0] ALU_LUI  = 4'b1100;

  // Bit positions inside the 10-bit control vector
  localparam int CTRL_W          = 10;
  localparam int CTRL_REG_DST    = 0;
  localparam int CTRL_BRANCH_EQ  = 1;
  localparam int CTRL_MEM_READ   = 2;
  localparam int CTRL_MEM_TO_REG = 3;
  localparam int CTRL_MEM_WRITE  = 4;
  localparam int CTRL_ALU_SRC    = 5;
  localparam int CTRL_REG_WRITE  = 6;
  localparam int CTRL_EXTEND     = 7;
  localparam int CTRL_BRANCH_NE  = 8;
  localparam int CTRL_JUMP       = 9;

  function automatic logic [31:0] extend_imm(input logic [15:0] imm, input logic sign_ext);
    return sign_ext ? {{16{imm[15]}}, imm} : {16'h0000, imm};
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational 32-bit ALU: arithmetic, logic, compares, shifts of B by shamt and LUI.
module alu_core
  import mips_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  alu_ctl,
  input  logic [4:0]  shamt,
  output logic [31:0] result,
  output logic        zero
);

  always_comb begin
    result = '0;
    case (alu_ctl)
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_ADD:  result = a + b;
      ALU_XOR:  result = a ^ b;
      ALU_NOR:  result = ~(a | b);
      ALU_SUB:  result = a - b;
      ALU_SLT:  result = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: result = {31'b0, a < b};
      ALU_SLL:  result = b << shamt;
      ALU_SRL:  result = b >> shamt;
      ALU_SRA:  result = $unsigned($signed(b) >>> shamt);
      ALU_LUI:  result = {b[15:0], 16'h0000};
      default:  result = '0;
    endcase
  end

  assign zero = (result == 32'd0);

endmodule

// File: rtl/mips_exec_decode.sv
// Single-cycle MIPS decode + execute slice: main control, ALU control and
// immediate extension feed alu_core; every output is registered once.
module mips_exec_decode
  import mips_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       instr,
  input  logic [31:0]       rs_data,
  input  logic [31:0]       rt_data,
  output logic [CTRL_W-1:0] ctrl,
  output logic [2:0]        alu_op,
  output logic [3:0]        alu_ctl,
  output logic [31:0]       imm_ext,
  output logic [31:0]       alu_result,
  output logic              zero
);

  logic [5:0]  opcode;
  logic [4:0]  rs_addr, rt_addr, rd_addr;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic        unused_fields;

  assign opcode  = instr[31:26];
  assign rs_addr = instr[25:21];
  assign rt_addr = instr[20:16];
  assign rd_addr = instr[15:11];
  assign shamt   = instr[10:6];
  assign funct   = instr[5:0];
  assign imm     = instr[15:0];
  // Register numbers are consumed by the register file, not by this stage
  assign unused_fields = ^{rs_addr, rt_addr, rd_addr};

  logic [CTRL_W-1:0] ctrl_next;
  logic [2:0]        alu_op_next;
  logic [3:0]        alu_ctl_next;
  logic [31:0]       imm_ext_next;
  logic [31:0]       alu_b;
  logic [31:0]       result_next;
  logic              zero_next;

  always_comb begin
    ctrl_next   = '0;
    alu_op_next = ALUOP_ADD;
    case (opcode)
      OP_RTYPE: begin
        ctrl_next[CTRL_REG_DST]   = 1'b1;
        ctrl_next[CTRL_REG_WRITE] = 1'b1;
        alu_op_next               = ALUOP_FUNCT;
      end
      OP_LW: begin
        ctrl_next[CTRL_MEM_READ]   = 1'b1;
        ctrl_next[CTRL_MEM_TO_REG] = 1'b1;
        ctrl_next[CTRL_ALU_SRC]    = 1'b1;
        ctrl_next[CTRL_REG_WRITE]  = 1'b1;
        ctrl_next[CTRL_EXTEND]     = 1'b1;
      end
      OP_SW: begin
        ctrl_next[CTRL_MEM_WRITE] = 1'b1;
        ctrl_next[CTRL_ALU_SRC]   = 1'b1;
        ctrl_next[CTRL_EXTEND]    = 1'b1;
      end
      OP_BEQ: begin
        ctrl_next[CTRL_BRANCH_EQ] = 1'b1;
        ctrl_next[CTRL_EXTEND]    = 1'b1;
        alu_op_next               = ALUOP_SUB;
      end
      OP_BNE: begin
        ctrl_next[CTRL_BRANCH_NE] = 1'b1;
        ctrl_next[CTRL_EXTEND]    = 1'b1;
        alu_op_next               = ALUOP_SUB;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
        ctrl_next[CTRL_ALU_SRC]   = 1'b1;
        ctrl_next[CTRL_REG_WRITE] = 1'b1;
        ctrl_next[CTRL_EXTEND]    = 1'b1;
        if (opcode == OP_SLTI)       alu_op_next = ALUOP_SLT;
        else if (opcode == OP_SLTIU) alu_op_next = ALUOP_SLTU;
      end
      // Logical immediates and lui take the zero-extended immediate
      OP_ANDI, OP_ORI, OP_LUI: begin
        ctrl_next[CTRL_ALU_SRC]   = 1'b1;
        ctrl_next[CTRL_REG_WRITE] = 1'b1;
        if (opcode == OP_ANDI)     alu_op_next = ALUOP_AND;
        else if (opcode == OP_ORI) alu_op_next = ALUOP_OR;
        else                       alu_op_next = ALUOP_LUI;
      end
      OP_J: ctrl_next[CTRL_JUMP] = 1'b1;
      default: ctrl_next = '0;
    endcase
  end

  always_comb begin
    alu_ctl_next = ALU_ADD;
    case (alu_op_next)
      ALUOP_ADD:  alu_ctl_next = ALU_ADD;
      ALUOP_SUB:  alu_ctl_next = ALU_SUB;
      ALUOP_AND:  alu_ctl_next = ALU_AND;
      ALUOP_OR:   alu_ctl_next = ALU_OR;
      ALUOP_SLT:  alu_ctl_next = ALU_SLT;
      ALUOP_SLTU: alu_ctl_next = ALU_SLTU;
      ALUOP_LUI:  alu_ctl_next = ALU_LUI;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD, FN_ADDU: alu_ctl_next = ALU_ADD;
          FN_SUB, FN_SUBU: alu_ctl_next = ALU_SUB;
          FN_AND:          alu_ctl_next = ALU_AND;
          FN_OR:           alu_ctl_next = ALU_OR;
          FN_XOR:          alu_ctl_next = ALU_XOR;
          FN_NOR:          alu_ctl_next = ALU_NOR;
          FN_SLT:          alu_ctl_next = ALU_SLT;
          FN_SLTU:         alu_ctl_next = ALU_SLTU;
          FN_SLL:          alu_ctl_next = ALU_SLL;
          FN_SRL:          alu_ctl_next = ALU_SRL;
          FN_SRA:          alu_ctl_next = ALU_SRA;
          default:         alu_ctl_next = ALU_ADD;
        endcase
      end
      default: alu_ctl_next = ALU_ADD;
    endcase
  end

  assign imm_ext_next = extend_imm(imm, ctrl_next[CTRL_EXTEND]);
  assign alu_b        = ctrl_next[CTRL_ALU_SRC] ? imm_ext_next : rt_data;

  alu_core u_alu_core (
    .a       (rs_data),
    .b       (alu_b),
    .alu_ctl (alu_ctl_next),
    .shamt   (shamt),
    .result  (result_next),
    .zero    (zero_next)
  );

  logic [CTRL_W-1:0] ctrl_reg;
  logic [2:0]        alu_op_reg;
  logic [3:0]        alu_ctl_reg;
  logic [31:0]       imm_ext_reg;
  logic [31:0]       result_reg;
  logic              zero_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ctrl_reg    <= '0;
      alu_op_reg  <= '0;
      alu_ctl_reg <= '0;
      imm_ext_reg <= '0;
      result_reg  <= '0;
      zero_reg    <= 1'b0;
    end else begin
      ctrl_reg    <= ctrl_next;
      alu_op_reg  <= alu_op_next;
      alu_ctl_reg <= alu_ctl_next;
      imm_ext_reg <= imm_ext_next;
      result_reg  <= result_next;
      zero_reg    <= zero_next;
    end
  end

  assign ctrl       = ctrl_reg;
  assign alu_op     = alu_op_reg;
  assign alu_ctl    = alu_ctl_reg;
  assign imm_ext    = imm_ext_reg;
  assign alu_result = result_reg;
  assign zero       = zero_reg;

endmodule

// File: tb/tb_mips_exec_decode.sv
// Self-checking bench: directed cases plus randomized instructions compared
// against a behavioural per-instruction model.
module tb_mips_exec_decode;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instr = '0;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic [9:0]  ctrl;
  logic [2:0]  alu_op;
  logic [3:0]  alu_ctl;
  logic [31:0] imm_ext;
  logic [31:0] alu_result;
  logic        zero;

  int checks = 0;
  int errors = 0;

  mips_exec_decode dut (
    .clock      (clock),
    .reset      (reset),
    .instr      (instr),
    .rs_data    (rs_data),
    .rt_data    (rt_data),
    .ctrl       (ctrl),
    .alu_op     (alu_op),
    .alu_ctl    (alu_ctl),
    .imm_ext    (imm_ext),
    .alu_result (alu_result),
    .zero       (zero)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [9:0]  ctrl;
    logic [2:0]  aop;
    logic [3:0]  actl;
    logic [31:0] imm;
    logic [31:0] res;
    logic        z;
  } exp_t;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // ctrl bit positions: 0 RegDst,1 BEQ,2 MemRead,3 MemtoReg,4 MemWrite,
  // 5 ALUSrc,6 RegWrite,7 ExtendType,8 BNE,9 Jump
  function automatic logic [9:0] flags(input string names);
    logic [9:0] f = '0;
    for (int i = 0; i < names.len(); i++) f[names[i] - "0"] = 1'b1;
    return f;
  endfunction

  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] rt);
    exp_t        e;
    logic [5:0]  op = ins[31:26];
    logic [5:0]  fn = ins[5:0];
    int          sh = int'(ins[10:6]);
    logic [31:0] b;
    e.ctrl = '0; e.aop = 3'b000; e.actl = 4'b0010; e.res = '0;
    case (op)
      6'h00: begin e.ctrl = flags("06");    e.aop = 3'b010; end
      6'h23: e.ctrl = flags("23567");
      6'h2B: e.ctrl = flags("457");
      6'h04: begin e.ctrl = flags("17");    e.aop = 3'b001; end
      6'h05: begin e.ctrl = flags("78");    e.aop = 3'b001; end
      6'h08, 6'h09: e.ctrl = flags("567");
      6'h0A: begin e.ctrl = flags("567");   e.aop = 3'b101; end
      6'h0B: begin e.ctrl = flags("567");   e.aop = 3'b110; end
      6'h0C: begin e.ctrl = flags("56");    e.aop = 3'b011; end
      6'h0D: begin e.ctrl = flags("56");    e.aop = 3'b100; end
      6'h0F: begin e.ctrl = flags("56");    e.aop = 3'b111; end
      6'h02: e.ctrl = flags("9");
      default: e.ctrl = '0;
    endcase
    e.imm = e.ctrl[7] ? 32'(signed'(ins[15:0])) : 32'(ins[15:0]);
    b = e.ctrl[5] ? e.imm : rt;
    if (op == 6'h00) begin
      case (fn)
        6'h22, 6'h23: begin e.actl = 4'b0110; e.res = a - b; end
        6'h24: begin e.actl = 4'b0000; e.res = a & b; end
        6'h25: begin e.actl = 4'b0001; e.res = a | b; end
        6'h26: begin e.actl = 4'b0011; e.res = a ^ b; end
        6'h27: begin e.actl = 4'b0100; e.res = ~(a | b); end
        6'h2A: begin e.actl = 4'b0111; e.res = (signed'(a) < signed'(b)) ? 1 : 0; end
        6'h2B: begin e.actl = 4'b1000; e.res = (a < b) ? 1 : 0; end
        6'h00: begin e.actl = 4'b1001; e.res = b * (33'd1 << sh); end
        6'h02: begin e.actl = 4'b1010; e.res = b / (33'd1 << sh); end
        6'h03: begin
          e.actl = 4'b1011;
          e.res = b;
          for (int i = 0; i < sh; i++) e.res = {e.res[31], e.res[31:1]};
        end
        default: e.res = a + b;
      endcase
    end else begin
      case (op)
        6'h04, 6'h05: begin e.actl = 4'b0110; e.res = a - b; end
        6'h0A: begin e.actl = 4'b0111; e.res = (signed'(a) < signed'(b)) ? 1 : 0; end
        6'h0B: begin e.actl = 4'b1000; e.res = (a < b) ? 1 : 0; end
        6'h0C: begin e.actl = 4'b0000; e.res = a & b; end
        6'h0D: begin e.actl = 4'b0001; e.res = a | b; end
        6'h0F: begin e.actl = 4'b1100; e.res = {ins[15:0], 16'h0000}; end
        default: e.res = a + b;
      endcase
    end
    e.z = (e.res == 0);
    return e;
  endfunction

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input int sh, input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  task automatic check_all(input string tag, input exp_t e);
    check({tag, ".ctrl"},   32'(ctrl),    32'(e.ctrl));
    check({tag, ".alu_op"}, 32'(alu_op),  32'(e.aop));
    check({tag, ".alu_ctl"},32'(alu_ctl), 32'(e.actl));
    check({tag, ".imm_ext"},imm_ext,      e.imm);
    check({tag, ".result"}, alu_result,   e.res);
    check({tag, ".zero"},   32'(zero),    32'(e.z));
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".ctrl"},   32'(ctrl),    32'd0);
    check({tag, ".alu_op"}, 32'(alu_op),  32'd0);
    check({tag, ".alu_ctl"},32'(alu_ctl), 32'd0);
    check({tag, ".imm_ext"},imm_ext,      32'd0);
    check({tag, ".result"}, alu_result,   32'd0);
    check({tag, ".zero"},   32'(zero),    32'd0);
  endtask

  // Drive at negedge, let one rising edge register it, sample 1 time unit later
  task automatic step(input string tag, input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    @(negedge clock);
    instr = ins; rs_data = a; rt_data = b;
    e = model(ins, a, b);
    @(posedge clock);
    #1;
    $display("%s instr=%h rs=%h rt=%h -> ctrl=%b alu_ctl=%b imm=%h res=%h z=%b",
             tag, ins, a, b, ctrl, alu_ctl, imm_ext, alu_result, zero);
    check_all(tag, e);
  endtask

  logic [5:0] op_list [14] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h09,
                               6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0F, 6'h02, 6'h3F};
  logic [5:0] fn_list [13] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                               6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03};

  initial begin
    // Reset held across edges: everything stays zero
    repeat (2) @(posedge clock);
    #1;
    check_zero("reset_hold");

    // Deassert mid-cycle; the next edge registers the inputs present then
    #2 reset = 1'b0;
    step("add", 32'h01095020, 32'd5, 32'd7);
    check("add.ctrl_bits", 32'(ctrl), 32'(flags("06")));
    check("add.result12", alu_result, 32'd12);

    step("beq", 32'h1109FFFF, 32'h1234, 32'h1234);
    check("beq.ctrl_bits", 32'(ctrl), 32'(flags("17")));
    check("beq.zero1", 32'(zero), 32'd1);
    check("beq.imm", imm_ext, 32'hFFFFFFFF);

    step("slt", rtype(8, 9, 10, 0, 6'h2A), 32'hFFFFFFFF, 32'd1);
    check("slt.result1", alu_result, 32'd1);
    step("sltu", rtype(8, 9, 10, 0, 6'h2B), 32'hFFFFFFFF, 32'd1);
    check("sltu.result0", alu_result, 32'd0);

    step("sra", rtype(0, 9, 10, 4, 6'h03), 32'h0, 32'h80000000);
    check("sra.result", alu_result, 32'hF8000000);
    step("srl", rtype(0, 9, 10, 4, 6'h02), 32'h0, 32'h80000000);
    check("srl.result", alu_result, 32'h08000000);
    step("sll0", rtype(0, 9, 10, 0, 6'h00), 32'h0, 32'hA5A5_0F0F);
    check("sll0.pass", alu_result, 32'hA5A5_0F0F);

    step("ori", itype(6'h0D, 8, 9, 16'h8001), 32'h0, 32'h0);
    check("ori.imm", imm_ext, 32'h00008001);
    step("lui", itype(6'h0F, 0, 9, 16'h8001), 32'h0, 32'h0);
    check("lui.result", alu_result, 32'h80010000);
    step("op3f", itype(6'h3F, 8, 9, 16'h1234), 32'h11, 32'h22);
    check("op3f.ctrl", 32'(ctrl), 32'd0);

    // Asynchronous reset with nonzero outputs registered
    step("pre_rst", 32'h01095020, 32'd5, 32'd7);
    #2 reset = 1'b1;
    #1;
    check_zero("async_rst");
    @(posedge clock);
    #1;
    check_zero("rst_held");
    #2 reset = 1'b0;

    for (int n = 0; n < 300; n++) begin
      logic [31:0] ins, a, b, r;
      r = $urandom();
      ins = $urandom();
      if (r[2:0] != 3'd0) ins[31:26] = op_list[$urandom_range(0, 13)];
      if (ins[31:26] == 6'h00 && r[5:3] != 3'd0) ins[5:0] = fn_list[$urandom_range(0, 12)];
      a = $urandom();
      b = $urandom();
      if (r[7:6] == 2'd0) b = a;
      if (r[9:8] == 2'd0) a = 32'($urandom_range(0, 15));
      step($sformatf("rnd%0d", n), ins, a, b);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
